// File: rtl/fence_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fence_sequencer
// Purpose  : Orders store drain, D$/I$/TLB flushes and commit ack for fences.
// Revision : 1.0
// ============================================================================
module fence_sequencer #(
  parameter int DRAIN_TIMEOUT = 1024,
  parameter int CNT_W         = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  input  logic [1:0]       req_kind_i,
  input  logic             halt_i,
  input  logic             kill_i,
  input  logic             no_st_pending_i,
  output logic             dcache_flush_o,
  input  logic             dcache_flush_ack_i,
  output logic             icache_flush_o,
  output logic             tlb_flush_o,
  output logic             done_o,
  output logic             flush_pipeline_o,
  output logic             busy_o,
  output logic             timeout_o,
  output logic             err_o,
  input  logic             err_clr_i,
  output logic [CNT_W-1:0] fence_count_o
);

  localparam int DC_W = $clog2(DRAIN_TIMEOUT);
  localparam logic [DC_W-1:0] C_CNT_MAX = DC_W'(DRAIN_TIMEOUT - 1);
  localparam logic [DC_W-1:0] C_CNT_PRE = DC_W'(DRAIN_TIMEOUT - 2);

  localparam logic [1:0] C_K_FENCE  = 2'd0;
  localparam logic [1:0] C_K_SFENCE = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRAIN  = 3'd1,
    S_DFLUSH = 3'd2,
    S_IFLUSH = 3'd3,
    S_TLB    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_kind;
  logic              r_kill;
  logic [DC_W-1:0]   r_drain_cnt;
  logic              w_timeout;
  logic              r_dflush;
  logic              r_iflush;
  logic              r_tlb;
  logic              r_done;
  logic              r_busy;
  logic              r_timeout;
  logic              r_err;
  logic [CNT_W-1:0]  r_count;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid_i && !halt_i && !kill_i) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (kill_i)               w_next = S_IDLE;
        else if (no_st_pending_i) w_next = (r_kind == C_K_SFENCE) ? S_TLB : S_DFLUSH;
      end
      S_DFLUSH: begin
        // A kill seen at any point during the flush only takes effect at the ack.
        if (dcache_flush_ack_i) begin
          if (r_kill || kill_i)          w_next = S_IDLE;
          else if (r_kind == C_K_FENCE)  w_next = S_DONE;
          else                           w_next = S_IFLUSH;
        end
      end
      S_IFLUSH: w_next = kill_i ? S_IDLE : S_DONE;
      S_TLB:    w_next = kill_i ? S_IDLE : S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Registered one cycle early so the pulse lands in the cycle where the
  // counter reads DRAIN_TIMEOUT-1.
  assign w_timeout = (r_state == S_DRAIN) && !kill_i && !no_st_pending_i &&
                     (r_drain_cnt == C_CNT_PRE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_kind      <= 2'd0;
      r_kill      <= 1'b0;
      r_drain_cnt <= '0;
      r_dflush    <= 1'b0;
      r_iflush    <= 1'b0;
      r_tlb       <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
      r_err       <= 1'b0;
      r_count     <= '0;
    end else begin
      r_state  <= w_next;
      r_dflush <= (w_next == S_DFLUSH);
      r_iflush <= (w_next == S_IFLUSH);
      r_tlb    <= (w_next == S_TLB);
      r_done   <= (w_next == S_DONE);
      r_busy   <= (w_next != S_IDLE);

      if (r_state == S_IDLE && w_next == S_DRAIN) begin
        r_kind      <= req_kind_i;
        r_drain_cnt <= '0;
      end else if (r_state == S_DRAIN && !no_st_pending_i && r_drain_cnt != C_CNT_MAX) begin
        r_drain_cnt <= r_drain_cnt + DC_W'(1);
      end

      if (w_next != S_DFLUSH) r_kill <= 1'b0;
      else if (kill_i)        r_kill <= 1'b1;

      r_timeout <= w_timeout;
      if (w_timeout)      r_err <= 1'b1;
      else if (err_clr_i) r_err <= 1'b0;

      if (r_state == S_DONE) r_count <= r_count + CNT_W'(1);
    end
  end

  assign dcache_flush_o   = r_dflush;
  assign icache_flush_o   = r_iflush;
  assign tlb_flush_o      = r_tlb;
  assign done_o           = r_done;
  assign flush_pipeline_o = r_done;
  assign busy_o           = r_busy;
  assign timeout_o        = r_timeout;
  assign err_o            = r_err;
  assign fence_count_o    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fence_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fence_sequencer
// Purpose  : Directed self-checking bench for fence_sequencer.
// Revision : 1.0
// ============================================================================
module tb_fence_sequencer;

  localparam int CW = 3;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_valid_i;
  logic [1:0]    req_kind_i;
  logic          halt_i;
  logic          kill_i;
  logic          no_st_pending_i;
  logic          dcache_flush_o;
  logic          dcache_flush_ack_i;
  logic          icache_flush_o;
  logic          tlb_flush_o;
  logic          done_o;
  logic          flush_pipeline_o;
  logic          busy_o;
  logic          timeout_o;
  logic          err_o;
  logic          err_clr_i;
  logic [CW-1:0] fence_count_o;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] dm, im, tm, dn, fp, bz, to;

  fence_sequencer #(.DRAIN_TIMEOUT(4), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_kind_i(req_kind_i),
    .halt_i(halt_i), .kill_i(kill_i), .no_st_pending_i(no_st_pending_i),
    .dcache_flush_o(dcache_flush_o), .dcache_flush_ack_i(dcache_flush_ack_i),
    .icache_flush_o(icache_flush_o), .tlb_flush_o(tlb_flush_o), .done_o(done_o),
    .flush_pipeline_o(flush_pipeline_o), .busy_o(busy_o), .timeout_o(timeout_o),
    .err_o(err_o), .err_clr_i(err_clr_i), .fence_count_o(fence_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic idle_inputs();
    req_valid_i = 0; req_kind_i = 0; halt_i = 0; kill_i = 0;
    no_st_pending_i = 1; dcache_flush_ack_i = 0; err_clr_i = 0;
  endtask

  // Cycle c0 is the request cycle; bit c of each mask is the output seen in cycle c.
  task automatic run_seq(input logic [1:0] kind, input int stall, input int ack_cyc,
                         input int kill_cyc, input int clr_cyc, input int ncyc);
    dm = 0; im = 0; tm = 0; dn = 0; fp = 0; bz = 0; to = 0;
    for (int c = 0; c < ncyc; c++) begin
      req_valid_i = (c == 0); req_kind_i = kind; halt_i = 0;
      no_st_pending_i = (c >= stall); dcache_flush_ack_i = (c == ack_cyc);
      kill_i = (c == kill_cyc); err_clr_i = (c == clr_cyc);
      dm[c] = dcache_flush_o; im[c] = icache_flush_o; tm[c] = tlb_flush_o;
      dn[c] = done_o; fp[c] = flush_pipeline_o; bz[c] = busy_o; to[c] = timeout_o;
      step();
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1;
    step(); step();
    rst_i = 0;
    step();
    n_cmp++; if ({dcache_flush_o, icache_flush_o, tlb_flush_o, done_o, flush_pipeline_o, busy_o, timeout_o, err_o} !== 8'h00) begin n_fail++; $display("FAIL reset_outs got=%b exp=00000000", {dcache_flush_o, icache_flush_o, tlb_flush_o, done_o, flush_pipeline_o, busy_o, timeout_o, err_o}); end
    n_cmp++; if (fence_count_o !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", fence_count_o); end
  endtask

  task automatic test_fence();
    run_seq(2'd0, 0, 2, 99, 99, 6);
    n_cmp++; if (dn !== 32'h08) begin n_fail++; $display("FAIL fence_done got=%h exp=08", dn); end
    n_cmp++; if (fp !== 32'h08) begin n_fail++; $display("FAIL fence_flushpipe got=%h exp=08", fp); end
    n_cmp++; if (dm !== 32'h04) begin n_fail++; $display("FAIL fence_dflush got=%h exp=04", dm); end
    n_cmp++; if ((im | tm) !== 32'h0) begin n_fail++; $display("FAIL fence_itlb got=%h exp=0", im | tm); end
    n_cmp++; if (bz !== 32'h0E) begin n_fail++; $display("FAIL fence_busy got=%h exp=0e", bz); end
    n_cmp++; if (fence_count_o !== 3'd1) begin n_fail++; $display("FAIL fence_count got=%0d exp=1", fence_count_o); end
  endtask

  task automatic test_fence_i();
    run_seq(2'd1, 5, 8, 99, 99, 12);
    n_cmp++; if (dm !== 32'h1C0) begin n_fail++; $display("FAIL fencei_dflush got=%h exp=1c0", dm); end
    n_cmp++; if (im !== 32'h200) begin n_fail++; $display("FAIL fencei_iflush got=%h exp=200", im); end
    n_cmp++; if (dn !== 32'h400) begin n_fail++; $display("FAIL fencei_done got=%h exp=400", dn); end
    n_cmp++; if (bz !== 32'h7FE) begin n_fail++; $display("FAIL fencei_busy got=%h exp=7fe", bz); end
    n_cmp++; if (to !== 32'h10) begin n_fail++; $display("FAIL fencei_timeout got=%h exp=10", to); end
    n_cmp++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL fencei_err got=%b exp=1", err_o); end
    n_cmp++; if (fence_count_o !== 3'd2) begin n_fail++; $display("FAIL fencei_count got=%0d exp=2", fence_count_o); end
  endtask

  task automatic test_sfence_halt();
    logic seen_busy;
    seen_busy = 0;
    req_valid_i = 1; req_kind_i = 2'd2; halt_i = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      seen_busy |= busy_o;
    end
    n_cmp++; if (seen_busy !== 1'b0) begin n_fail++; $display("FAIL halt_busy got=%b exp=0", seen_busy); end
    run_seq(2'd2, 0, 99, 99, 99, 5);
    n_cmp++; if (tm !== 32'h04) begin n_fail++; $display("FAIL sfence_tlb got=%h exp=04", tm); end
    n_cmp++; if (dn !== 32'h08) begin n_fail++; $display("FAIL sfence_done got=%h exp=08", dn); end
    n_cmp++; if ((dm | im) !== 32'h0) begin n_fail++; $display("FAIL sfence_di got=%h exp=0", dm | im); end
    n_cmp++; if (bz !== 32'h0E) begin n_fail++; $display("FAIL sfence_busy got=%h exp=0e", bz); end
  endtask

  task automatic test_timeout();
    err_clr_i = 1; step(); err_clr_i = 0;
    n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL pre_clr_err got=%b exp=0", err_o); end
    // err_clr in c3 collides with the timeout set.
    run_seq(2'd0, 10, 11, 99, 3, 14);
    n_cmp++; if (to !== 32'h10) begin n_fail++; $display("FAIL to_pulse got=%h exp=10", to); end
    n_cmp++; if (dm !== 32'h800) begin n_fail++; $display("FAIL to_dflush got=%h exp=800", dm); end
    n_cmp++; if (dn !== 32'h1000) begin n_fail++; $display("FAIL to_done got=%h exp=1000", dn); end
    n_cmp++; if (bz !== 32'h1FFE) begin n_fail++; $display("FAIL to_busy got=%h exp=1ffe", bz); end
    n_cmp++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL to_err_set_wins got=%b exp=1", err_o); end
    n_cmp++; if (fence_count_o !== 3'd4) begin n_fail++; $display("FAIL to_count got=%0d exp=4", fence_count_o); end
    err_clr_i = 1; step(); err_clr_i = 0;
    n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL to_err_clr got=%b exp=0", err_o); end
  endtask

  task automatic test_kill();
    run_seq(2'd0, 0, 5, 3, 99, 8);
    n_cmp++; if (dm !== 32'h3C) begin n_fail++; $display("FAIL killdf_dflush got=%h exp=3c", dm); end
    n_cmp++; if (dn !== 32'h0) begin n_fail++; $display("FAIL killdf_done got=%h exp=0", dn); end
    n_cmp++; if (bz !== 32'h3E) begin n_fail++; $display("FAIL killdf_busy got=%h exp=3e", bz); end
    run_seq(2'd0, 5, 1, 2, 99, 5);
    n_cmp++; if (bz !== 32'h06) begin n_fail++; $display("FAIL killdr_busy got=%h exp=06", bz); end
    n_cmp++; if ((dm | dn | to) !== 32'h0) begin n_fail++; $display("FAIL killdr_outs got=%h exp=0", dm | dn | to); end
    n_cmp++; if (fence_count_o !== 3'd4) begin n_fail++; $display("FAIL kill_count got=%0d exp=4", fence_count_o); end
  endtask

  task automatic test_async_reset();
    run_seq(2'd0, 0, 99, 99, 99, 4);
    n_cmp++; if (dcache_flush_o !== 1'b1) begin n_fail++; $display("FAIL ar_pre_dflush got=%b exp=1", dcache_flush_o); end
    #2 rst_i = 1;
    #1;
    n_cmp++; if ({dcache_flush_o, icache_flush_o, tlb_flush_o, done_o, flush_pipeline_o, busy_o, timeout_o, err_o} !== 8'h00) begin n_fail++; $display("FAIL ar_outs got=%b exp=00000000", {dcache_flush_o, icache_flush_o, tlb_flush_o, done_o, flush_pipeline_o, busy_o, timeout_o, err_o}); end
    n_cmp++; if (fence_count_o !== 3'd0) begin n_fail++; $display("FAIL ar_count got=%0d exp=0", fence_count_o); end
    step();
    rst_i = 0;
    step();
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL ar_post_busy got=%b exp=0", busy_o); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] dmask;
    dmask = 0;
    req_valid_i = 1; req_kind_i = 2'd0; no_st_pending_i = 1; dcache_flush_ack_i = 1;
    for (int c = 0; c < 8; c++) begin
      dmask[c] = done_o;
      step();
    end
    idle_inputs();
    n_cmp++; if (dmask !== 8'h88) begin n_fail++; $display("FAIL b2b_done got=%h exp=88", dmask); end
    n_cmp++; if (fence_count_o !== 3'd2) begin n_fail++; $display("FAIL b2b_count got=%0d exp=2", fence_count_o); end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 5; k++) run_seq(2'd0, 0, 2, 99, 99, 5);
    n_cmp++; if (fence_count_o !== 3'd7) begin n_fail++; $display("FAIL wrap_max got=%0d exp=7", fence_count_o); end
    run_seq(2'd3, 0, 2, 99, 99, 6);
    n_cmp++; if (im !== 32'h08) begin n_fail++; $display("FAIL wrap_ext_iflush got=%h exp=08", im); end
    n_cmp++; if (fence_count_o !== 3'd0) begin n_fail++; $display("FAIL wrap_zero got=%0d exp=0", fence_count_o); end
  endtask

  initial begin
    test_reset();
    test_fence();
    test_fence_i();
    test_sfence_halt();
    test_timeout();
    test_kill();
    test_async_reset();
    test_back_to_back();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
